// File: rtl/serial_adder_16bit.sv
// Bit-serial 16-bit two's-complement adder: one full-adder slice plus a carry flop, LSB first over 16 cycles.
// Optional feature: define SERIAL_ADDER_SATURATE_EN to clamp sum to the signed range on overflow.
module serial_adder_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] sum,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic        [15:0] ra_q, rb_q, ps_q;
  logic        [3:0]  cnt_q;
  logic               c_q;
  logic signed [15:0] sum_q;
  logic               ovf_q;

  logic               s_bit, c_next, last_bit, ovf_d;
  logic signed [15:0] result_d, sum_d;

`ifdef SERIAL_ADDER_SATURATE_EN
  function automatic logic signed [15:0] saturate(input logic signed [15:0] val,
                                                  input logic ovf,
                                                  input logic a_sign);
    if (!ovf)
      return val;
    return a_sign ? 16'sh8000 : 16'sh7FFF;
  endfunction
`endif

  assign s_bit    = ra_q[0] ^ rb_q[0] ^ c_q;
  assign c_next   = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
  assign last_bit = (state_q == SHIFT) && (cnt_q == 4'd15);
  assign result_d = {s_bit, ps_q[15:1]};
  // On the final bit ra_q[0]/rb_q[0] are the latched operand sign bits.
  assign ovf_d    = (ra_q[0] == rb_q[0]) && (s_bit != ra_q[0]);

`ifdef SERIAL_ADDER_SATURATE_EN
  assign sum_d = saturate(result_d, ovf_d, ra_q[0]);
`else
  assign sum_d = result_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd15) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == SHIFT);
    done     = (state_q == DONE);
    sum      = sum_q;
    overflow = ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q  <= '0;
      rb_q  <= '0;
      ps_q  <= '0;
      cnt_q <= '0;
      c_q   <= 1'b0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        ra_q  <= A;
        rb_q  <= B;
        ps_q  <= '0;
        cnt_q <= '0;
        c_q   <= 1'b0;
      end else if (state_q == SHIFT) begin
        ra_q  <= {1'b0, ra_q[15:1]};
        rb_q  <= {1'b0, rb_q[15:1]};
        ps_q  <= result_d;
        cnt_q <= cnt_q + 4'd1;
        c_q   <= c_next;
      end
      if (last_bit) begin
        sum_q <= sum_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_16bit.sv
// Scoreboard bench for serial_adder_16bit: driver pushes expected results, monitor pops on each done pulse.
module tb_serial_adder_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [15:0] sum;
  logic        overflow, busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_run = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_sum;
    logic        exp_ovf;
    int          acc_cyc;
  } txn_t;

  txn_t sb_q[$];
  logic [15:0] last_sum = '0;
  logic        last_ovf = 1'b0;

  serial_adder_16bit dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .sum(sum), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic txn_t model(input logic [15:0] a, input logic [15:0] b);
    txn_t t;
    int   s;
    s = int'($signed(a)) + int'($signed(b));
    t.a = a;
    t.b = b;
    t.exp_ovf = (s > 32767) || (s < -32768);
    t.exp_sum = s[15:0];
`ifdef SERIAL_ADDER_SATURATE_EN
    if (t.exp_ovf) t.exp_sum = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    t.acc_cyc = 0;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares each completed result against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy && done) check("busy_done_overlap", 1, 0);
      if (busy) busy_run++;
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          txn_t t;
          t = sb_q.pop_front();
          check($sformatf("sum %h+%h", t.a, t.b), {16'h0, sum}, {16'h0, t.exp_sum});
          check($sformatf("ovf %h+%h", t.a, t.b), {31'h0, overflow}, {31'h0, t.exp_ovf});
          check("latency", cyc - t.acc_cyc, 16);
          check("busy_cycles", busy_run, 16);
          last_sum = t.exp_sum;
          last_ovf = t.exp_ovf;
        end
        busy_run = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("done_timeout", 1, 0);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b);
    txn_t t;
    wait_idle();
    A = a;
    B = b;
    start = 1'b1;
    t = model(a, b);
    t.acc_cyc = cyc + 1;
    sb_q.push_back(t);
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 1, 0);
  endtask

  initial begin
    #12;
    check("rst_sum", {16'h0, sum}, 0);
    check("rst_ovf", {31'h0, overflow}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'h0, busy}, 0);

    do_op(16'd2, 16'd2);
    do_op(16'd5, 16'hFFFE);
    do_op(16'hFFFE, 16'hFFFE);
    do_op(16'h7FFF, 16'h0001);
    do_op(16'h8000, 16'hFFFF);
    do_op(16'h8000, 16'h8000);
    drain();

    // Starts during SHIFT and DONE must be ignored.
    do_op(16'd7, 16'd9);
    repeat (3) @(negedge clk);
    A = 16'd100; B = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    A = 16'd100; B = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("ignored_start_busy", {31'h0, busy}, 0);
    check("hold_sum", {16'h0, sum}, 32'd16);
    do_op(16'd100, 16'd100);
    drain();

    // Asynchronous reset in the middle of bit 8.
    wait_idle();
    A = 16'h1234; B = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_sum", {16'h0, sum}, 0);
    check("midrst_ovf", {31'h0, overflow}, 0);
    check("midrst_busy", {31'h0, busy}, 0);
    check("midrst_done", {31'h0, done}, 0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_done_busy", {31'h0, busy}, 0);
    do_op(16'h1234, 16'h1111);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 0) rb = ra;
      do_op(ra, rb);
    end
    drain();

    repeat (5) @(negedge clk);
    check("final_hold_sum", {16'h0, sum}, {16'h0, last_sum});
    check("final_hold_ovf", {31'h0, overflow}, {31'h0, last_ovf});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
